// File: rtl/ov7670_stream_gen_if.sv
// OV7670-style parallel camera bus: byte clock, frame/line syncs and pixel byte.
// The master drives the bus; the slave is the capture side.
interface ov7670_stream_gen_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] pdata;

    modport master (output pclk, output vsync, output href, output pdata);
    modport slave  (input  pclk, input  vsync, input  href, input  pdata);
endinterface

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 RGB444 ("xR GB") camera source with selectable test patterns.
// pclk runs at clock/2; every stream output changes only on the pclk falling edge.
module ov7670_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 784,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 510,
    parameter int VSYNC_LINES = 3,
    parameter int V_BP        = 17,
    parameter int BAR_W       = 80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_rgb,
    output logic        frame_start,
    output logic [15:0] frame_count,
    ov7670_stream_gen_if.master cam
);
    localparam int BYTE_W = $clog2(2 * H_TOTAL);
    localparam int LINE_W = $clog2(V_TOTAL);
    localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(2 * H_TOTAL - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_TOTAL - 1);
    localparam logic [BAR_CW-1:0] BAR_LAST  = BAR_CW'(BAR_W - 1);
    localparam logic [15:0] VSYNC_END = 16'(VSYNC_LINES);
    localparam logic [15:0] ACT_FIRST = 16'(VSYNC_LINES + V_BP);
    localparam logic [15:0] ACT_END   = 16'(VSYNC_LINES + V_BP + V_ACTIVE);
    localparam logic [15:0] HREF_END  = 16'(2 * H_ACTIVE);

    typedef enum logic {IDLE, RUN} state_e;

    state_e              state_q, state_d;
    logic                pclk_q;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [BAR_CW-1:0]   barpx_q, barpx_d;
    logic [2:0]          baridx_q, baridx_d;
    logic [1:0]          pat_q, pat_d;
    logic [11:0]         rgb_q, rgb_d;
    logic [15:0]         fc_q, fc_d;
    logic                fs_q;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          pdata_q, pdata_d;

    logic                tick, frame_end, launch;
    logic [15:0]         px_x, px_y, line16, byte16;
    logic [11:0]         px_rgb;

    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'h0FF;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF0F;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // A tick is the clock edge on which pclk falls; all stream state moves only then.
    assign tick      = pclk_q;
    assign frame_end = (byte_q == BYTE_LAST) && (line_q == LINE_LAST);
    assign launch    = tick && enable && ((state_q == IDLE) || frame_end);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:    if (enable) state_d = RUN;
                RUN:     if (frame_end && !enable) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        byte_d   = byte_q;
        line_d   = line_q;
        barpx_d  = barpx_q;
        baridx_d = baridx_q;
        pat_d    = pat_q;
        rgb_d    = rgb_q;
        fc_d     = fc_q;
        vsync_d  = vsync_q;
        href_d   = href_q;
        pdata_d  = pdata_q;

        if (launch) begin
            byte_d   = '0;
            line_d   = '0;
            barpx_d  = '0;
            baridx_d = '0;
            pat_d    = pattern_sel;
            rgb_d    = solid_rgb;
            fc_d     = fc_q + 16'd1;
        end else if (tick && (state_q == RUN) && !frame_end) begin
            if (byte_q == BYTE_LAST) begin
                byte_d   = '0;
                line_d   = line_q + 1'b1;
                barpx_d  = '0;
                baridx_d = '0;
            end else begin
                byte_d = byte_q + 1'b1;
                // Leaving an odd byte means the next byte opens a new pixel.
                if (byte_q[0]) begin
                    if (barpx_q == BAR_LAST) begin
                        barpx_d  = '0;
                        baridx_d = baridx_q + 3'd1;
                    end else begin
                        barpx_d = barpx_q + 1'b1;
                    end
                end
            end
        end

        line16 = 16'(line_d);
        byte16 = 16'(byte_d);
        px_x   = byte16 >> 1;
        px_y   = line16 - ACT_FIRST;

        case (pat_d)
            2'd0:    px_rgb = rgb_d;
            2'd1:    px_rgb = bar_rgb(baridx_d);
            2'd2:    px_rgb = {px_x[3:0], px_y[3:0], fc_d[3:0]};
            default: px_rgb = (px_x[5] ^ px_y[5]) ? 12'hFFF : 12'h000;
        endcase

        if (tick) begin
            if (state_d == RUN) begin
                vsync_d = (line16 < VSYNC_END);
                href_d  = (line16 >= ACT_FIRST) && (line16 < ACT_END) && (byte16 < HREF_END);
                pdata_d = !href_d  ? 8'h00 :
                          byte_d[0] ? px_rgb[7:0] : {4'h0, px_rgb[11:8]};
            end else begin
                vsync_d = 1'b0;
                href_d  = 1'b0;
                pdata_d = 8'h00;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            pclk_q   <= 1'b0;
            byte_q   <= '0;
            line_q   <= '0;
            barpx_q  <= '0;
            baridx_q <= '0;
            pat_q    <= '0;
            rgb_q    <= '0;
            fc_q     <= '0;
            fs_q     <= 1'b0;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            pdata_q  <= '0;
        end else begin
            pclk_q   <= ~pclk_q;
            byte_q   <= byte_d;
            line_q   <= line_d;
            barpx_q  <= barpx_d;
            baridx_q <= baridx_d;
            pat_q    <= pat_d;
            rgb_q    <= rgb_d;
            fc_q     <= fc_d;
            fs_q     <= launch;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            pdata_q  <= pdata_d;
        end
    end

    assign cam.pclk    = pclk_q;
    assign cam.vsync   = vsync_q;
    assign cam.href    = href_q;
    assign cam.pdata   = pdata_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen on a reduced frame (20x10 slots, 16x4 active).
// Expected stream values come from a tick-indexed position model of the frame.
module tb_ov7670_stream_gen;
    localparam int HA  = 16;
    localparam int HT  = 20;
    localparam int VA  = 4;
    localparam int VT  = 10;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int BW  = 2;
    localparam int HT2 = 2 * HT;
    localparam int FRAME_TICKS = HT2 * VT;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] solid_rgb = 12'hA5C;
    logic        frame_start;
    logic [15:0] frame_count;

    ov7670_stream_gen_if cam ();

    ov7670_stream_gen #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .VSYNC_LINES(VS), .V_BP(VBP), .BAR_W(BW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .solid_rgb  (solid_rgb),
        .frame_start(frame_start),
        .frame_count(frame_count),
        .cam        (cam)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-shape statistics gathered while capturing a frame.
    int       vs_ticks, href_rises, runs_ok, run_len, first_href, pix_ok;
    logic     href_prev;
    logic [7:0] rx_hi;

    function automatic logic [11:0] exp_pixel(input int x, input int y, input int pat,
                                              input logic [11:0] rgb, input logic [15:0] fc);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        case (pat)
            0: return rgb;
            1: case ((x / BW) % 8)
                   0: return 12'hFFF;
                   1: return 12'hFF0;
                   2: return 12'h0FF;
                   3: return 12'h0F0;
                   4: return 12'hF0F;
                   5: return 12'hF00;
                   6: return 12'h00F;
                   default: return 12'h000;
               endcase
            2: return {xv[3:0], yv[3:0], fc[3:0]};
            default: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    function automatic logic [9:0] exp_stream(input int t, input int pat,
                                              input logic [11:0] rgb, input logic [15:0] fc);
        int line, b;
        logic vs, hr;
        logic [11:0] px;
        logic [7:0] d;
        line = t / HT2;
        b    = t % HT2;
        vs   = (line < VS);
        hr   = (line >= VS + VBP) && (line < VS + VBP + VA) && (b < 2 * HA);
        px   = exp_pixel(b / 2, line - (VS + VBP), pat, rgb, fc);
        d    = !hr ? 8'h00 : ((b % 2) == 0) ? {4'h0, px[11:8]} : px[7:0];
        return {vs, hr, d};
    endfunction

    // Advance from one tick to the next: pclk must rise then fall, stream held meanwhile.
    task automatic step_tick();
        logic vs0, hr0;
        logic [7:0] pd0;
        vs0 = cam.vsync;
        hr0 = cam.href;
        pd0 = cam.pdata;
        @(posedge clock); #1;
        check("pclk_high", cam.pclk, 1'b1);
        check("fs_midtick", frame_start, 1'b0);
        check("stable", {cam.vsync, cam.href, cam.pdata}, {vs0, hr0, pd0});
        @(posedge clock); #1;
        check("pclk_low", cam.pclk, 1'b0);
    endtask

    task automatic capture(input int t_from, input int t_to, input int pat,
                           input logic [11:0] rgb, input logic [15:0] fc);
        logic [9:0] e;
        for (int t = t_from; t < t_to; t++) begin
            if (t != 0) begin
                step_tick();
                check("fs_inframe", frame_start, 1'b0);
            end else begin
                vs_ticks = 0; href_rises = 0; runs_ok = 0; run_len = 0;
                first_href = -1; pix_ok = 0; href_prev = 1'b0; rx_hi = 8'h00;
            end
            e = exp_stream(t, pat, rgb, fc);
            check("vsync", cam.vsync, e[9]);
            check("href", cam.href, e[8]);
            check("pdata", cam.pdata, e[7:0]);
            if (cam.vsync) vs_ticks++;
            if (cam.href) begin
                if (!href_prev) begin
                    href_rises++;
                    if (first_href < 0) first_href = t;
                end
                if ((run_len % 2) == 0) rx_hi = cam.pdata;
                else if ({rx_hi[3:0], cam.pdata} == rgb) pix_ok++;
                run_len++;
            end else begin
                if (href_prev && run_len == 2 * HA) runs_ok++;
                run_len = 0;
            end
            href_prev = cam.href;
        end
    endtask

    int cyc0;

    initial begin
        // Reset held for 5 clocks with enable already high.
        repeat (5) @(posedge clock);
        #1;
        check("rst_pclk", cam.pclk, 1'b0);
        check("rst_vsync", cam.vsync, 1'b0);
        check("rst_href", cam.href, 1'b0);
        check("rst_pdata", cam.pdata, 8'h00);
        check("rst_fs", frame_start, 1'b0);
        check("rst_fc", frame_count, 16'd0);
        reset = 1'b0;

        @(posedge clock); #1;
        check("rel_pclk1", cam.pclk, 1'b1);
        check("rel_fs1", frame_start, 1'b0);
        @(posedge clock); #1;
        check("rel_pclk0", cam.pclk, 1'b0);
        check("first_fs", frame_start, 1'b1);
        check("first_fc", frame_count, 16'd1);
        cyc0 = cyc;

        // Frame 1: solid A5C; inputs changed mid-frame must not show until the next frame.
        capture(0, 200, 0, 12'hA5C, 16'd1);
        pattern_sel = 2'd1;
        solid_rgb   = 12'h000;
        capture(200, FRAME_TICKS, 0, 12'hA5C, 16'd1);
        check("vsync_ticks", vs_ticks, 2 * HT2);
        check("href_pulses", href_rises, VA);
        check("href_runs32", runs_ok, VA);
        check("first_href", first_href, (VS + VBP) * HT2);
        check("rx_pixels", pix_ok, HA * VA);

        step_tick();
        check("fs_frame2", frame_start, 1'b1);
        check("fc_frame2", frame_count, 16'd2);
        check("frame_clocks", cyc - cyc0, 2 * FRAME_TICKS);

        // Frame 2: colour bars; enable dropped in line 3 lets the frame finish.
        capture(0, 3 * HT2 + 5, 1, 12'h000, 16'd2);
        enable = 1'b0;
        capture(3 * HT2 + 5, FRAME_TICKS, 1, 12'h000, 16'd2);
        for (int i = 0; i < 12; i++) begin
            step_tick();
            check("idle_fs", frame_start, 1'b0);
            check("idle_out", {cam.vsync, cam.href, cam.pdata}, 10'h000);
            check("idle_fc", frame_count, 16'd2);
        end

        // Frame 3: gradient, launched by re-raising enable, cut short by reset mid-href.
        pattern_sel = 2'd2;
        enable      = 1'b1;
        step_tick();
        check("fs_frame3", frame_start, 1'b1);
        check("fc_frame3", frame_count, 16'd3);
        capture(0, (VS + VBP) * HT2 + 6, 2, 12'h000, 16'd3);
        check("href_before_rst", cam.href, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mrst_href", cam.href, 1'b0);
        check("mrst_pdata", cam.pdata, 8'h00);
        check("mrst_vsync", cam.vsync, 1'b0);
        check("mrst_pclk", cam.pclk, 1'b0);
        check("mrst_fc", frame_count, 16'd0);
        @(posedge clock); #1;
        pattern_sel = 2'd0;
        solid_rgb   = 12'h3C7;
        reset       = 1'b0;
        @(posedge clock); #1;
        check("rst2_fs_early", frame_start, 1'b0);
        @(posedge clock); #1;
        check("rst2_fs", frame_start, 1'b1);
        check("rst2_fc", frame_count, 16'd1);
        capture(0, FRAME_TICKS, 0, 12'h3C7, 16'd1);
        check("rx_pixels2", pix_ok, HA * VA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
